multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS core.
- Consumes the 6-bit OpCode that the datapath exports and drives every datapath control input, one instruction phase per clock.
- Paces instruction fetch and data access with a single memory-ready handshake.
- Flags unsupported opcodes and pulses once per retired instruction.

---
 rtl/mips_defs.sv | 38 +++
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// mips_defs: opcodes, datapath select encodings and control FSM states
// shared by the multi-cycle MIPS datapath, its controller and the bench.
package mips_defs;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_e;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS core; one
// instruction phase per clock, memory phases paced by mem_ready.
module multicycle_control
    import mips_defs::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);
    logic [STATE_W-1:0] state_q, state_d;
    logic               rdy;

    assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= STATE_W'(ST_FETCH);
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = STATE_W'(ST_FETCH);
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALU_ADD;
        PCSource    = PC_ALU;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            STATE_W'(ST_FETCH): begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = rdy;
                PCWrite = rdy;
                state_d = STATE_W'(rdy ? ST_DECODE : ST_FETCH);
            end
            STATE_W'(ST_DECODE): begin
                ALUSrcB = SRCB_IMM_SH;
                state_d = (OpCode == OP_LW || OpCode == OP_SW) ? STATE_W'(ST_MEM_ADDR)  :
                          (OpCode == OP_RTYPE)                 ? STATE_W'(ST_EXECUTE)   :
                          (OpCode == OP_BEQ)                   ? STATE_W'(ST_BRANCH)    :
                          (OpCode == OP_J)                     ? STATE_W'(ST_JUMP)      :
                          (OpCode == OP_ADDI)                  ? STATE_W'(ST_ADDI_EXEC) :
                                                                 STATE_W'(ST_FETCH);
                illegal_op = state_d == STATE_W'(ST_FETCH);
                instr_done = illegal_op;
            end
            STATE_W'(ST_MEM_ADDR): begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (OpCode == OP_LW) ? STATE_W'(ST_MEM_READ)  :
                          (OpCode == OP_SW) ? STATE_W'(ST_MEM_WRITE) : STATE_W'(ST_FETCH);
            end
            STATE_W'(ST_MEM_READ): begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = STATE_W'(rdy ? ST_MEM_WB : ST_MEM_READ);
            end
            STATE_W'(ST_MEM_WB): begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(ST_MEM_WRITE): begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = rdy;
                state_d    = STATE_W'(rdy ? ST_FETCH : ST_MEM_WRITE);
            end
            STATE_W'(ST_EXECUTE): begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = STATE_W'(ST_R_WB);
            end
            STATE_W'(ST_R_WB): begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            STATE_W'(ST_BRANCH): begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PC_ALUOUT;
                instr_done  = 1'b1;
            end
            STATE_W'(ST_JUMP): begin
                PCWrite    = 1'b1;
                PCSource   = PC_JUMP;
                instr_done = 1'b1;
            end
            STATE_W'(ST_ADDI_EXEC): begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = STATE_W'(ST_ADDI_WB);
            end
            STATE_W'(ST_ADDI_WB): begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = STATE_W'(ST_FETCH);
        endcase
        // While reset is held the state already reads FETCH; kill its request too.
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            illegal_op  = 1'b0;
            instr_done  = 1'b0;
            IorD        = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_RT;
            ALUOp       = ALU_ADD;
            PCSource    = PC_ALU;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle checks of state and every control
// output against hand-derived control words.
module tb_multicycle_control;
    import mips_defs::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op, instr_done;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [17:0] ctrl;
    int errors = 0;
    int checks = 0;

    // {PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA}_ALUSrcB_ALUOp_PCSource_{illegal instr_done}
    localparam logic [17:0] C_RST     = 18'b0000000000_00_00_00_00;
    localparam logic [17:0] C_FETCH_R = 18'b1001010000_01_00_00_00;
    localparam logic [17:0] C_FETCH_W = 18'b0001000000_01_00_00_00;
    localparam logic [17:0] C_DEC     = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] C_DEC_ILL = 18'b0000000000_11_00_00_11;
    localparam logic [17:0] C_MADDR   = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] C_MREAD   = 18'b0011000000_00_00_00_00;
    localparam logic [17:0] C_MWB     = 18'b0000001010_00_00_00_01;
    localparam logic [17:0] C_MWR_W   = 18'b0010100000_00_00_00_00;
    localparam logic [17:0] C_MWR_R   = 18'b0010100000_00_00_00_01;
    localparam logic [17:0] C_EXEC    = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] C_RWB     = 18'b0000000110_00_00_00_01;
    localparam logic [17:0] C_BR      = 18'b0100000001_00_01_01_01;
    localparam logic [17:0] C_JMP     = 18'b1000000000_00_00_10_01;
    localparam logic [17:0] C_AEX     = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] C_AWB     = 18'b0000000010_00_00_00_01;

    multicycle_control #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, instr_done};

    task automatic look(input logic [3:0] es, input logic [17:0] ec, input string tag);
        #1;
        checks++;
        assert ({state, ctrl} === {es, ec}) else begin
            errors++;
            $error("FAIL %s: observed state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                   tag, state, ctrl, es, ec);
        end
    endtask

    task automatic cyc(input logic [3:0] es, input logic [17:0] ec, input string tag);
        look(es, ec, tag);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        OpCode    = OP_LW;
        #2;
        look(ST_FETCH, C_RST, "reset_hold");
        repeat (2) @(posedge clk);
        #2;
        look(ST_FETCH, C_RST, "reset_hold_after_edges");
        reset = 1'b1;
        cyc(ST_FETCH,    C_FETCH_R, "lw_fetch");
        cyc(ST_DECODE,   C_DEC,     "lw_decode");
        cyc(ST_MEM_ADDR, C_MADDR,   "lw_addr");
        cyc(ST_MEM_READ, C_MREAD,   "lw_read");
        cyc(ST_MEM_WB,   C_MWB,     "lw_wb");

        OpCode = OP_SW;
        cyc(ST_FETCH,    C_FETCH_R, "sw_fetch");
        cyc(ST_DECODE,   C_DEC,     "sw_decode");
        cyc(ST_MEM_ADDR, C_MADDR,   "sw_addr");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(ST_MEM_WRITE, C_MWR_W, "sw_write_wait");
        mem_ready = 1'b1;
        cyc(ST_MEM_WRITE, C_MWR_R, "sw_write_done");

        OpCode = OP_BEQ;
        cyc(ST_FETCH,  C_FETCH_R, "beq_fetch");
        cyc(ST_DECODE, C_DEC,     "beq_decode");
        cyc(ST_BRANCH, C_BR,      "beq_branch");

        OpCode = OP_J;
        cyc(ST_FETCH,  C_FETCH_R, "j_fetch");
        cyc(ST_DECODE, C_DEC,     "j_decode");
        cyc(ST_JUMP,   C_JMP,     "j_jump");

        OpCode = OP_RTYPE;
        cyc(ST_FETCH,   C_FETCH_R, "r_fetch");
        cyc(ST_DECODE,  C_DEC,     "r_decode");
        cyc(ST_EXECUTE, C_EXEC,    "r_exec");
        cyc(ST_R_WB,    C_RWB,     "r_wb");

        OpCode = OP_ADDI;
        cyc(ST_FETCH,     C_FETCH_R, "addi_fetch");
        cyc(ST_DECODE,    C_DEC,     "addi_decode");
        cyc(ST_ADDI_EXEC, C_AEX,     "addi_exec");
        cyc(ST_ADDI_WB,   C_AWB,     "addi_wb");

        OpCode = 6'b111111;
        cyc(ST_FETCH,  C_FETCH_R, "ill_fetch");
        cyc(ST_DECODE, C_DEC_ILL, "ill_decode");

        OpCode    = OP_J;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc(ST_FETCH, C_FETCH_W, "fetch_wait");
        mem_ready = 1'b1;
        cyc(ST_FETCH,  C_FETCH_R, "fetch_ready");
        cyc(ST_DECODE, C_DEC,     "fetchw_decode");
        cyc(ST_JUMP,   C_JMP,     "fetchw_jump");

        OpCode = OP_LW;
        cyc(ST_FETCH,    C_FETCH_R, "rlw_fetch");
        cyc(ST_DECODE,   C_DEC,     "rlw_decode");
        cyc(ST_MEM_ADDR, C_MADDR,   "rlw_addr");
        mem_ready = 1'b0;
        cyc(ST_MEM_READ, C_MREAD,   "rlw_read_wait");
        look(ST_MEM_READ, C_MREAD,  "rlw_read_wait2");
        reset = 1'b0;
        look(ST_FETCH, C_RST, "async_reset");
        mem_ready = 1'b1;
        @(posedge clk);
        #2;
        look(ST_FETCH, C_RST, "reset_mid_hold");
        reset = 1'b1;
        cyc(ST_FETCH,    C_FETCH_R, "post_reset_fetch");
        cyc(ST_DECODE,   C_DEC,     "post_reset_decode");
        cyc(ST_MEM_ADDR, C_MADDR,   "post_reset_addr");
        cyc(ST_MEM_READ, C_MREAD,   "post_reset_read");
        cyc(ST_MEM_WB,   C_MWB,     "post_reset_wb");
        cyc(ST_FETCH,    C_FETCH_R, "post_reset_next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
